// File: rtl/id_hazard_if.sv
// Decode-stage hazard bus: ID/EX hazard inputs in, pipeline sequencing controls and statistics out.
interface id_hazard_if #(parameter int CNT_W = 32);
  logic [4:0]       id_rs1_addr;
  logic [4:0]       id_rs2_addr;
  logic [4:0]       ex_rd_addr;
  logic             ex_mem_read;
  logic             ex_branch_taken;
  logic             imem_busy;
  logic             dmem_busy;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             ctrl_flush;
  logic             pipe_freeze;
  logic [1:0]       state;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_rs1_addr, id_rs2_addr, ex_rd_addr, ex_mem_read, ex_branch_taken,
           imem_busy, dmem_busy,
    input  pc_write, ifid_write, ifid_flush, ctrl_flush, pipe_freeze,
           state, mem_timeout, stall_cycles, flush_count
  );

  modport slave (
    input  id_rs1_addr, id_rs2_addr, ex_rd_addr, ex_mem_read, ex_branch_taken,
           imem_busy, dmem_busy,
    output pc_write, ifid_write, ifid_flush, ctrl_flush, pipe_freeze,
           state, mem_timeout, stall_cycles, flush_count
  );
endinterface

// File: rtl/id_hazard_ctrl.sv
// Hazard controller around decode: load-use stalls, redirect flushes, memory-wait freezes, stats.
module id_hazard_ctrl #(
  parameter int BRANCH_PENALTY = 1,
  parameter int MEM_TIMEOUT    = 255,
  parameter int CNT_W          = 32
) (
  input logic         clk,
  input logic         rst,
  id_hazard_if.slave  hz
);
  localparam int PW = (BRANCH_PENALTY > 1) ? $clog2(BRANCH_PENALTY) : 1;
  localparam int BW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [PW-1:0] PEN_LD = PW'(BRANCH_PENALTY - 1);
  localparam logic [BW-1:0] MT     = BW'(MEM_TIMEOUT);

  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, FLUSH = 2'd2} st_t;

  st_t              state_q, state_nxt;
  logic [PW-1:0]    pen_q, pen_nxt;
  logic [BW-1:0]    busy_q, busy_inc;
  logic             to_q;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             busy, lu, redir;
  logic             pc_we, ifid_we, ifid_fl, ctrl_fl, freeze;

  assign busy = hz.imem_busy | hz.dmem_busy;
  assign lu   = hz.ex_mem_read && (hz.ex_rd_addr != 5'd0) &&
                ((hz.ex_rd_addr == hz.id_rs1_addr) || (hz.ex_rd_addr == hz.id_rs2_addr));
  assign busy_inc = (busy_q == MT) ? busy_q : busy_q + 1'b1;

  // Priority: reset > busy > pending flush > redirect > load-use > normal.
  always_comb begin
    pc_we     = 1'b1;
    ifid_we   = 1'b1;
    ifid_fl   = 1'b0;
    ctrl_fl   = 1'b0;
    freeze    = 1'b0;
    redir     = 1'b0;
    state_nxt = state_q;
    pen_nxt   = pen_q;
    if (!rst) begin
      pc_we   = 1'b0;
      ifid_we = 1'b0;
      ifid_fl = 1'b1;
      ctrl_fl = 1'b1;
    end else if (busy) begin
      pc_we   = 1'b0;
      ifid_we = 1'b0;
      freeze  = 1'b1;
      if (state_q == RUN) state_nxt = MEM_WAIT;
    end else if (state_q == FLUSH) begin
      ifid_fl = 1'b1;
      ctrl_fl = 1'b1;
      pen_nxt = pen_q - 1'b1;
      if (pen_q == PW'(1)) state_nxt = RUN;
    end else if (hz.ex_branch_taken) begin
      ifid_fl = 1'b1;
      ctrl_fl = 1'b1;
      redir   = 1'b1;
      if (BRANCH_PENALTY > 1) begin
        pen_nxt   = PEN_LD;
        state_nxt = FLUSH;
      end else begin
        state_nxt = RUN;
      end
    end else if (lu) begin
      pc_we     = 1'b0;
      ifid_we   = 1'b0;
      ctrl_fl   = 1'b1;
      state_nxt = RUN;
    end else begin
      state_nxt = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      pen_q   <= '0;
      busy_q  <= '0;
      to_q    <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_nxt;
      pen_q   <= pen_nxt;
      busy_q  <= busy ? busy_inc : '0;
      if (busy && (busy_inc == MT)) to_q <= 1'b1;
      if (!pc_we && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (redir && (flush_q != '1))  flush_q <= flush_q + 1'b1;
    end
  end

  assign hz.pc_write     = pc_we;
  assign hz.ifid_write   = ifid_we;
  assign hz.ifid_flush   = ifid_fl;
  assign hz.ctrl_flush   = ctrl_fl;
  assign hz.pipe_freeze  = freeze;
  assign hz.state        = state_q;
  assign hz.mem_timeout  = to_q;
  assign hz.stall_cycles = stall_q;
  assign hz.flush_count  = flush_q;
endmodule

// File: doc/id_hazard_ctrl.md
# id_hazard_ctrl

Pipeline hazard controller that sequences the IF/ID and ID/EX pipeline registers around the decode stage. It detects load-use hazards, branch/jump redirects and instruction/data-memory wait states. From these it drives PC write-enable, IF/ID hold and flush, the decode-stage `CtrlSignalFlush` bubble input, and a global freeze. It sits beside the decode stage, taking source addresses from the instruction in ID and destination/load status from the instruction in EX, and keeps saturating stall and flush statistics.

## Interface
- `BRANCH_PENALTY`, default 1: cycles (≥1) that IF/ID and ID/EX are flushed per taken redirect.
- `MEM_TIMEOUT`, default 255: consecutive busy cycles (≥1) after which `mem_timeout` sets.
- `CNT_W`, default 32: width of the statistics counters.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `id_rs1_addr` in 5: rs1 field of the instruction in ID (instr[19:15]).
- `id_rs2_addr` in 5: rs2 field of the instruction in ID (instr[24:20]).
- `ex_rd_addr` in 5: rd of the instruction in EX.
- `ex_mem_read` in 1: the instruction in EX is a load.
- `ex_branch_taken` in 1: EX resolved a taken branch or jump this cycle.
- `imem_busy` in 1: instruction memory not ready.
- `dmem_busy` in 1: data memory not ready.
- `pc_write` out 1: PC register update enable.
- `ifid_write` out 1: IF/ID register load enable.
- `ifid_flush` out 1: load NOP into IF/ID.
- `ctrl_flush` out 1: connects to the decode stage's `CtrlSignalFlush`; bubbles the ID/EX control.
- `pipe_freeze` out 1: hold every pipeline register (ID/EX, EX/MEM, MEM/WB).
- `state` out 2: current FSM state (RUN=0, MEM_WAIT=1, FLUSH=2).
- `mem_timeout` out 1: sticky; set when the busy run reaches `MEM_TIMEOUT`.
- `stall_cycles` out CNT_W: count of cycles with `pc_write`=0.
- `flush_count` out CNT_W: count of accepted redirects.

## Operation
- Control outputs are combinational from state, counters and current inputs. State, counters and flags are registered.
- Reset (`rst`=0 at an edge): state=RUN, penalty counter=0, busy counter=0, `mem_timeout`=0, `stall_cycles`=0, `flush_count`=0.
- While `rst`=0, outputs are `pc_write`=0, `ifid_write`=0, `ifid_flush`=1, `ctrl_flush`=1, `pipe_freeze`=0.
- `busy` = `imem_busy` | `dmem_busy`.
- `lu` = `ex_mem_read` & (`ex_rd_addr`≠0) & (`ex_rd_addr`==`id_rs1_addr` | `ex_rd_addr`==`id_rs2_addr`).
- Priority is busy > redirect > load-use > normal.
- Normal: `pc_write`=1, `ifid_write`=1, all flush and freeze outputs 0.
- Busy, in any state:
  - `pipe_freeze`=1, `pc_write`=0, `ifid_write`=0, `ifid_flush`=0, `ctrl_flush`=0.
  - Next state is MEM_WAIT from RUN; FLUSH stays FLUSH.
  - The penalty counter holds.
  - The busy counter increments, saturating at `MEM_TIMEOUT`. When it equals `MEM_TIMEOUT`, `mem_timeout` sets and stays set until reset.
- Any non-busy cycle clears the busy counter. MEM_WAIT with busy=0 evaluates exactly as RUN that cycle.
- Redirect (RUN or MEM_WAIT, `ex_branch_taken`=1, busy=0):
  - `pc_write`=1, `ifid_write`=1, `ifid_flush`=1, `ctrl_flush`=1.
  - `flush_count` increments.
  - If `BRANCH_PENALTY`>1: load the penalty counter with `BRANCH_PENALTY`-1 and go to FLUSH. Otherwise go to RUN.
- FLUSH with busy=0:
  - `ifid_flush`=1, `ctrl_flush`=1, `pc_write`=1, `ifid_write`=1.
  - `ex_branch_taken` and `lu` are ignored.
  - The penalty counter decrements; it returns to RUN in the cycle the counter goes 1→0.
- Load-use (RUN or MEM_WAIT, busy=0, no redirect, `lu`=1):
  - `pc_write`=0, `ifid_write`=0, `ctrl_flush`=1.
  - Next state is RUN. The bubble in EX clears `lu` the following cycle.
- Statistics counters saturate at all-ones and never wrap. `stall_cycles` is not incremented during reset.

## Timing
- Hazard response is zero-latency: outputs react in the same cycle as the triggering inputs.
- A load-use stall costs exactly 1 cycle.
- A redirect flushes for exactly `BRANCH_PENALTY` non-busy cycles. Busy cycles inside FLUSH extend it without consuming penalty.
- Busy deasserting while in MEM_WAIT: that same cycle is a normal, redirect or load-use cycle.
- Simultaneous busy, redirect and `lu`: freeze only. The redirect is re-evaluated when busy drops; EX is frozen, so `ex_branch_taken` is still presented.
- Reset asserted mid-FLUSH or mid-MEM_WAIT: the next edge forces RUN and clears all counters. No partial penalty survives.

## Test plan
- Load x5 in EX (`ex_mem_read`=1, `ex_rd_addr`=5) with `id_rs2_addr`=5 → one cycle of `pc_write`=0, `ifid_write`=0, `ctrl_flush`=1; next cycle normal; `stall_cycles`=1. Repeat with `ex_rd_addr`=0 → no stall.
- `BRANCH_PENALTY`=2, `ex_branch_taken` pulse for 1 cycle → `ifid_flush`=`ctrl_flush`=1 for 2 cycles, `state` 0→2→0, `flush_count`=1.
- `ex_branch_taken`=1 and `lu`=1 together → flush only, `pc_write`=1, `stall_cycles` unchanged.
- `dmem_busy` high for 3 cycles during FLUSH with penalty remaining 1 → `pipe_freeze`=1 for 3 cycles, then 1 flush cycle, then RUN.
- `MEM_TIMEOUT`=4, `imem_busy` held 6 cycles → `mem_timeout` rises after the 4th busy cycle and stays 1 after busy drops; `stall_cycles`=6.
- Reset (`rst`=0 for 1 edge) while in FLUSH with `flush_count`=3 → `state`=0, all counters 0, flush outputs 1 during reset, normal after.
